// File: rtl/ikari_video_regs_pkg.sv
// Shared types and helpers for the video control register bank.
// Readback is enabled by defining IKARI_VREGS_READBACK_EN.
package ikari_video_regs_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } vreg_fsm_t;

    localparam logic [7:0] DEFAULT_DBUF_MASK = 8'hF0;

    // Bit offset of register idx within a packed NUM_REGS*DATA_W bus.
    function automatic int unsigned reg_slice(input int unsigned idx, input int unsigned data_w);
        return idx * data_w;
    endfunction

endpackage

// File: rtl/ikari_vreg_cell.sv
// One control register: immediate (DBUF=0) or double-buffered with a commit-gated shadow.
module ikari_vreg_cell
    import ikari_video_regs_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter bit          DBUF   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_hit,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    output logic [DATA_W-1:0] active,
    output logic [DATA_W-1:0] shadow,
    output logic              pending
);

    if (DBUF) begin : g_dbuf
        // A write landing on the commit edge still sets pending so the new data is not lost.
        always_ff @(posedge clk) begin
            if (reset) begin
                active  <= '0;
                shadow  <= '0;
                pending <= 1'b0;
            end else begin
                if (commit && pending) begin
                    active <= shadow;
                end
                if (wr_hit) begin
                    shadow  <= wr_data;
                    pending <= 1'b1;
                end else if (commit) begin
                    pending <= 1'b0;
                end
            end
        end
    end else begin : g_imm
        always_ff @(posedge clk) begin
            if (reset) begin
                active <= '0;
            end else if (wr_hit) begin
                active <= wr_data;
            end
        end
        assign shadow  = '0;
        assign pending = 1'b0;
    end

endmodule

// File: rtl/ikari_video_regbank.sv
// CPU-to-video register bank: write pipe, vblank commit FSM and per-register cells.
// Optional registered readback port enabled by IKARI_VREGS_READBACK_EN.
module ikari_video_regbank
    import ikari_video_regs_pkg::*;
#(
    parameter int unsigned          NUM_REGS  = 8,
    parameter int unsigned          DATA_W    = 8,
    parameter int unsigned          ADDR_W    = $clog2(NUM_REGS),
    parameter logic [NUM_REGS-1:0]  DBUF_MASK = NUM_REGS'(DEFAULT_DBUF_MASK)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         vblank,
    input  logic                         frame_lock,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic [NUM_REGS-1:0]          pending,
    output logic                         commit_pulse,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [DATA_W-1:0]            rd_data
);

    logic                       pipe_valid;
    logic [ADDR_W-1:0]          pipe_addr;
    logic [DATA_W-1:0]          pipe_data;
    logic                       vblank_q;
    vreg_fsm_t                  state;
    logic                       rise_c;
    logic                       commit_c;
    logic [NUM_REGS-1:0]        wr_hit;
    logic [NUM_REGS*DATA_W-1:0] shadow_bus;

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid <= 1'b0;
            pipe_addr  <= '0;
            pipe_data  <= '0;
        end else begin
            pipe_valid <= wr_en;
            pipe_addr  <= wr_addr;
            pipe_data  <= wr_data;
        end
    end

    assign rise_c   = vblank && !vblank_q;
    assign commit_c = ((state == IDLE)  && rise_c && !frame_lock) ||
                      ((state == ARMED) && vblank && !frame_lock);

    // ARMED waits out frame_lock within the same blank; leaving blank abandons this frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            vblank_q     <= 1'b0;
            commit_pulse <= 1'b0;
        end else begin
            vblank_q     <= vblank;
            commit_pulse <= commit_c && (|pending);
            case (state)
                IDLE: begin
                    if (rise_c && frame_lock) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (!vblank || !frame_lock) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        assign wr_hit[i] = pipe_valid && (pipe_addr == ADDR_W'(i));

        ikari_vreg_cell #(
            .DATA_W (DATA_W),
            .DBUF   (DBUF_MASK[i])
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .wr_hit  (wr_hit[i]),
            .wr_data (pipe_data),
            .commit  (commit_c),
            .active  (regs_out[reg_slice(i, DATA_W) +: DATA_W]),
            .shadow  (shadow_bus[reg_slice(i, DATA_W) +: DATA_W]),
            .pending (pending[i])
        );
    end

`ifdef IKARI_VREGS_READBACK_EN
    // Readback shows what the video side will see after the next commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (rd_addr == ADDR_W'(i)) begin
                    rd_data <= pending[i] ? shadow_bus[reg_slice(i, DATA_W) +: DATA_W]
                                          : regs_out[reg_slice(i, DATA_W) +: DATA_W];
                end
            end
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^{rd_addr, shadow_bus};
    assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_ikari_video_regbank.sv
// Directed self-checking bench for ikari_video_regbank (NUM_REGS=6, regs 4/5 double-buffered).
module tb_ikari_video_regbank;

    localparam int unsigned NUM_REGS = 6;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned BUS_W    = NUM_REGS * DATA_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              vblank;
    logic              frame_lock;
    logic [BUS_W-1:0]  regs_out;
    logic [NUM_REGS-1:0] pending;
    logic              commit_pulse;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    int n_cmp = 0;
    int n_err = 0;

    ikari_video_regbank #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .vblank       (vblank),
        .frame_lock   (frame_lock),
        .regs_out     (regs_out),
        .pending      (pending),
        .commit_pulse (commit_pulse),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one write strobe for a single cycle; the pipe applies it one edge later.
    task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        vblank = 1'b0; frame_lock = 1'b0; rd_addr = '0;
        repeat (3) tick();
        check("rst_regs", 64'(regs_out), 64'h0);
        check("rst_pend", 64'(pending), 64'h0);
        check("rst_pulse", 64'(commit_pulse), 64'h0);
        reset = 1'b0;
        tick();

        // Immediate register: two-edge latency
        write(3'd1, 8'h5A);
        check("imm_e0", 64'(regs_out), 64'h0);
        tick();
        check("imm_e1", 64'(regs_out), 64'h0000_0000_5A00);
        check("imm_pend", 64'(pending), 64'h0);

        // Double-buffered write held until vblank rise
        write(3'd4, 8'h33);
        tick();
        check("dbuf_hold", 64'(regs_out), 64'h0000_0000_5A00);
        check("dbuf_pend", 64'(pending), 64'h10);
        vblank = 1'b1;
        tick();
        check("dbuf_commit", 64'(regs_out), 64'h0033_0000_5A00);
        check("dbuf_pend0", 64'(pending), 64'h0);
        check("dbuf_pulse", 64'(commit_pulse), 64'h1);
        tick();
        check("dbuf_pulse1", 64'(commit_pulse), 64'h0);
        vblank = 1'b0;
        tick();

        // frame_lock across rise, released 20 clk later inside blank
        write(3'd5, 8'h77);
        tick();
        check("lock_pend", 64'(pending), 64'h20);
        frame_lock = 1'b1; vblank = 1'b1;
        tick();
        check("lock_defer", 64'(regs_out), 64'h0033_0000_5A00);
        check("lock_nopulse", 64'(commit_pulse), 64'h0);
        repeat (19) tick();
        check("lock_still", 64'(pending), 64'h20);
        frame_lock = 1'b0;
        tick();
        check("lock_release", 64'(regs_out), 64'h7733_0000_5A00);
        check("lock_rel_pulse", 64'(commit_pulse), 64'h1);
        check("lock_rel_pend", 64'(pending), 64'h0);
        tick();
        vblank = 1'b0;
        tick();

        // Blank ends while locked: no commit until the next frame
        write(3'd4, 8'h44);
        tick();
        frame_lock = 1'b1; vblank = 1'b1;
        repeat (3) tick();
        vblank = 1'b0;
        tick();
        frame_lock = 1'b0;
        repeat (2) tick();
        check("miss_regs", 64'(regs_out), 64'h7733_0000_5A00);
        check("miss_pend", 64'(pending), 64'h10);
        check("miss_pulse", 64'(commit_pulse), 64'h0);
        vblank = 1'b1;
        tick();
        check("next_frame", 64'(regs_out), 64'h7744_0000_5A00);
        check("next_pulse", 64'(commit_pulse), 64'h1);
        vblank = 1'b0;
        tick();

        // Commit with nothing pending produces no pulse
        vblank = 1'b1;
        tick();
        check("empty_pulse", 64'(commit_pulse), 64'h0);
        vblank = 1'b0;
        tick();

        // Write and commit on the same edge for reg 5
        write(3'd5, 8'h11);
        tick();
        write(3'd5, 8'hBB);
        vblank = 1'b1;
        tick();
        check("same_active", 64'(regs_out), 64'h1144_0000_5A00);
        check("same_pend", 64'(pending), 64'h20);
        check("same_pulse", 64'(commit_pulse), 64'h1);
        vblank = 1'b0;
        tick();
        vblank = 1'b1;
        tick();
        check("same_next", 64'(regs_out), 64'hBB44_0000_5A00);
        check("same_next_pend", 64'(pending), 64'h0);
        vblank = 1'b0;
        tick();

        // Back-to-back writes: last wins
        write(3'd4, 8'hC1);
        write(3'd4, 8'hC2);
        tick();
        check("b2b_pend", 64'(pending), 64'h10);
        vblank = 1'b1;
        tick();
        check("b2b_last", 64'(regs_out), 64'hBBC2_0000_5A00);
        vblank = 1'b0;
        tick();

        // Out-of-range addresses dropped
        write(3'd7, 8'hFF);
        write(3'd6, 8'hEE);
        repeat (2) tick();
        check("oor_regs", 64'(regs_out), 64'hBBC2_0000_5A00);
        check("oor_pend", 64'(pending), 64'h0);

`ifdef IKARI_VREGS_READBACK_EN
        write(3'd5, 8'hC3);
        tick();
        rd_addr = 3'd5;
        tick();
        check("rb_shadow", 64'(rd_data), 64'hC3);
        rd_addr = 3'd1;
        tick();
        check("rb_active", 64'(rd_data), 64'h5A);
        rd_addr = 3'd7;
        tick();
        check("rb_oor", 64'(rd_data), 64'h0);
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick();
`else
        rd_addr = 3'd1;
        tick();
        check("rb_tied", 64'(rd_data), 64'h0);
`endif

        // Mid-frame reset discards pending shadows and in-flight writes
        write(3'd4, 8'h55);
        write(3'd5, 8'h66);
        tick();
        check("pre_rst_pend", 64'(pending), 64'h30);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h99;
        reset = 1'b1;
        tick();
        wr_en = 1'b0;
        check("mid_rst_regs", 64'(regs_out), 64'h0);
        check("mid_rst_pend", 64'(pending), 64'h0);
        check("mid_rst_pulse", 64'(commit_pulse), 64'h0);
        reset = 1'b0;
        repeat (2) tick();
        check("post_rst_pipe", 64'(regs_out), 64'h0);
        vblank = 1'b1;
        tick();
        check("post_rst_commit", 64'(regs_out), 64'h0);
        check("post_rst_pulse", 64'(commit_pulse), 64'h0);
        vblank = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
